cache_fill_ctrl: RTL and testbench

Miss-refill controller directly upstream of the compressed cache array. It accepts a miss address and fetches the 16-word line from memory as one burst, forwarding the demanded word as soon as it arrives. It passes the 512-bit raw line to the BDI compressor and returns with the compressed result. It then issues a single `cache_write_on_demand` write, tag plus both half-valid bits, into a victim way chosen round-robin per set.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/cache_fill_ctrl_if.sv | 52 +++++
 rtl/fill_victim_rr.sv | 29 ++
 rtl/cache_fill_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the miss-refill controller.
// Addresses split as tag [31:13], set [12:6], word-in-line [5:2].
package cache_pkg;

    localparam int TAG_FIELD  = 19;
    localparam int DATA_FIELD = 256;
    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam int WAYS       = 8;
    localparam int SETS       = 128;
    localparam int LINE_W     = 512;
    localparam int IDX_W      = 10;
    localparam int WAY_W      = 3;
    localparam int SET_W      = 7;
    localparam int WR_W       = 2 + TAG_FIELD + DATA_FIELD;

    localparam logic [7:0] MODE_RAW = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MREQ,
        ST_FILL,
        ST_CREQ,
        ST_CWAIT,
        ST_WRITE
    } fill_state_t;

    function automatic logic [TAG_FIELD-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[31:13];
    endfunction

    function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_WIDTH-1:0] a);
        return a[12:6];
    endfunction

    function automatic logic [3:0] addr_word(input logic [ADDR_WIDTH-1:0] a);
        return a[5:2];
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of the miss, memory-burst, compressor and cache-write channels of the refill controller.
// master = controller side, slave = surrounding memory/compressor/cache environment.
interface cache_fill_ctrl_if;
    import cache_pkg::*;

    logic                    miss_valid;
    logic                    miss_ready;
    logic [ADDR_WIDTH-1:0]   miss_addr;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_rsp_valid;
    logic [WORD_WIDTH-1:0]   mem_rsp_data;

    logic                    fill_word_valid;
    logic [WORD_WIDTH-1:0]   fill_word_data;

    logic                    cmp_req_valid;
    logic                    cmp_req_ready;
    logic [LINE_W-1:0]       cmp_req_data;
    logic                    cmp_rsp_valid;
    logic                    cmp_rsp_fit;
    logic [DATA_FIELD-1:0]   cmp_rsp_data;
    logic [7:0]              cmp_rsp_mode;
    logic [31:0]             cmp_rsp_base;

    logic                    cache_write_on_demand;
    logic [IDX_W-1:0]        cache_write_index;
    logic [WR_W-1:0]         cache_write_data;
    logic [7:0]              meta_write_mode;
    logic [31:0]             meta_write_base;
    logic                    fill_done;
    logic                    proto_err;

    modport master (
        input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               cmp_req_ready, cmp_rsp_valid, cmp_rsp_fit, cmp_rsp_data, cmp_rsp_mode, cmp_rsp_base,
        output miss_ready, mem_req_valid, mem_req_addr, fill_word_valid, fill_word_data,
               cmp_req_valid, cmp_req_data, cache_write_on_demand, cache_write_index,
               cache_write_data, meta_write_mode, meta_write_base, fill_done, proto_err
    );

    modport slave (
        output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               cmp_req_ready, cmp_rsp_valid, cmp_rsp_fit, cmp_rsp_data, cmp_rsp_mode, cmp_rsp_base,
        input  miss_ready, mem_req_valid, mem_req_addr, fill_word_valid, fill_word_data,
               cmp_req_valid, cmp_req_data, cache_write_on_demand, cache_write_index,
               cache_write_data, meta_write_mode, meta_write_base, fill_done, proto_err
    );

endinterface

// File: rtl/fill_victim_rr.sv
// Per-set round-robin victim pointer: way_o is a combinational read of the selected set.
// adv_i bumps only that set's pointer (mod 8) on the next edge; no backpressure.
module fill_victim_rr
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] set_i,
    input  logic             adv_i,
    output logic [WAY_W-1:0] way_o
);

    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] ptr_d;

    assign way_o = ptr_q[set_i];
    assign ptr_d = ptr_q[set_i] + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (adv_i) begin
            ptr_q[set_i] <= ptr_d;
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss refill: burst-fetch a 16-word line, forward the demanded word, compress, write one victim way.
// 20 cycles miss-accept to write with no stalls; every ready/valid stall adds exactly one cycle.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.master bus
);

    fill_state_t             state_q, state_d;
    logic [TAG_FIELD-1:0]    tag_q, tag_d;
    logic [SET_W-1:0]        set_q, set_d;
    logic [3:0]              word_q, word_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    fill_vld_q, fill_vld_d;
    logic [WORD_WIDTH-1:0]   fill_dat_q, fill_dat_d;
    logic                    wr_en_q, wr_en_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
    logic [WR_W-1:0]         wr_dat_q, wr_dat_d;
    logic [7:0]              mode_q, mode_d;
    logic [31:0]             base_q, base_d;
    logic                    proto_q, proto_d;
    logic                    rr_adv;
    logic [WAY_W-1:0]        rr_way;

    fill_victim_rr u_rr (
        .clk   (clk),
        .rst_n (rst),
        .set_i (set_q),
        .adv_i (rr_adv),
        .way_o (rr_way)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        set_d      = set_q;
        word_d     = word_q;
        wcnt_d     = wcnt_q;
        line_d     = line_q;
        fill_vld_d = 1'b0;
        fill_dat_d = fill_dat_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_dat_d   = wr_dat_q;
        mode_d     = mode_q;
        base_d     = base_q;
        rr_adv     = 1'b0;
        // A response word arriving while no burst is outstanding is dropped and flagged.
        proto_d    = proto_q | (bus.mem_rsp_valid && (state_q != ST_FILL));

        case (state_q)
            ST_IDLE: begin
                if (bus.miss_valid) begin
                    tag_d   = addr_tag(bus.miss_addr);
                    set_d   = addr_set(bus.miss_addr);
                    word_d  = addr_word(bus.miss_addr);
                    state_d = ST_MREQ;
                end
            end
            ST_MREQ: begin
                if (bus.mem_req_ready) begin
                    wcnt_d  = 4'd0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.mem_rsp_valid) begin
                    line_d[{wcnt_q, 5'd0} +: WORD_WIDTH] = bus.mem_rsp_data;
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == word_q) begin
                        fill_vld_d = 1'b1;
                        fill_dat_d = bus.mem_rsp_data;
                    end
                    if (wcnt_q == 4'd15) begin
                        state_d = ST_CREQ;
                    end
                end
            end
            ST_CREQ: begin
                if (bus.cmp_req_ready) begin
                    state_d = ST_CWAIT;
                end
            end
            ST_CWAIT: begin
                if (bus.cmp_rsp_valid) begin
                    // Victim is sampled and the pointer advanced here so the index is stable in WRITE.
                    wr_en_d  = 1'b1;
                    rr_adv   = 1'b1;
                    wr_idx_d = {rr_way, set_q};
                    if (bus.cmp_rsp_fit) begin
                        wr_dat_d = {2'b11, tag_q, bus.cmp_rsp_data};
                        mode_d   = bus.cmp_rsp_mode;
                        base_d   = bus.cmp_rsp_base;
                    end else begin
                        wr_dat_d = {2'b01, tag_q, line_q[DATA_FIELD-1:0]};
                        mode_d   = MODE_RAW;
                        base_d   = 32'd0;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q      <= '0;
            set_q      <= '0;
            word_q     <= '0;
            wcnt_q     <= '0;
            line_q     <= '0;
            fill_vld_q <= 1'b0;
            fill_dat_q <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_dat_q   <= '0;
            mode_q     <= '0;
            base_q     <= '0;
            proto_q    <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            set_q      <= set_d;
            word_q     <= word_d;
            wcnt_q     <= wcnt_d;
            line_q     <= line_d;
            fill_vld_q <= fill_vld_d;
            fill_dat_q <= fill_dat_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_dat_q   <= wr_dat_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            proto_q    <= proto_d;
        end
    end

    assign bus.miss_ready            = (state_q == ST_IDLE);
    assign bus.mem_req_valid         = (state_q == ST_MREQ);
    assign bus.cmp_req_valid         = (state_q == ST_CREQ);
    assign bus.mem_req_addr          = {tag_q, set_q, 6'd0};
    assign bus.fill_word_valid       = fill_vld_q;
    assign bus.fill_word_data        = fill_dat_q;
    assign bus.cmp_req_data          = line_q;
    assign bus.cache_write_on_demand = wr_en_q;
    assign bus.fill_done             = wr_en_q;
    assign bus.cache_write_index     = wr_idx_q;
    assign bus.cache_write_data      = wr_dat_q;
    assign bus.meta_write_mode       = mode_q;
    assign bus.meta_write_base       = base_q;
    assign bus.proto_err             = proto_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed-plus-random bench for cache_fill_ctrl against a transaction-level model of the refill.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_fill_ctrl_if ifc ();

    cache_fill_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;
    int rr_m [SETS];
    logic [IDX_W-1:0] last_idx;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifc.miss_valid    = 1'b0;
        ifc.miss_addr     = '0;
        ifc.mem_req_ready = 1'b0;
        ifc.mem_rsp_valid = 1'b0;
        ifc.mem_rsp_data  = '0;
        ifc.cmp_req_ready = 1'b0;
        ifc.cmp_rsp_valid = 1'b0;
        ifc.cmp_rsp_fit   = 1'b0;
        ifc.cmp_rsp_data  = '0;
        ifc.cmp_rsp_mode  = '0;
        ifc.cmp_rsp_base  = '0;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_miss_ready"}, ifc.miss_ready, 1);
        chk({pfx, "_mem_req_valid"}, ifc.mem_req_valid, 0);
        chk({pfx, "_mem_req_addr"}, ifc.mem_req_addr, 0);
        chk({pfx, "_fill_word_valid"}, ifc.fill_word_valid, 0);
        chk({pfx, "_fill_word_data"}, ifc.fill_word_data, 0);
        chk({pfx, "_cmp_req_valid"}, ifc.cmp_req_valid, 0);
        chk({pfx, "_cmp_req_data"}, ifc.cmp_req_data, 0);
        chk({pfx, "_wr_strobe"}, ifc.cache_write_on_demand, 0);
        chk({pfx, "_wr_index"}, ifc.cache_write_index, 0);
        chk({pfx, "_wr_data"}, ifc.cache_write_data, 0);
        chk({pfx, "_meta_mode"}, ifc.meta_write_mode, 0);
        chk({pfx, "_meta_base"}, ifc.meta_write_base, 0);
        chk({pfx, "_fill_done"}, ifc.fill_done, 0);
        chk({pfx, "_proto_err"}, ifc.proto_err, 0);
    endtask

    // One complete miss transaction; abort_at >= 0 stops right after that word is delivered.
    task automatic do_miss(input logic [31:0] a, input logic fit, input int ms, input int max_gap,
                           input int cs, input int abort_at, input logic fixed);
        logic [31:0]      w [16];
        logic [511:0]     line;
        logic [255:0]     cd;
        logic [7:0]       md;
        logic [31:0]      bs;
        logic [6:0]       s;
        logic [IDX_W-1:0] exp_idx;
        logic [WR_W-1:0]  exp_dat;
        int cyc, stalls, pulses, wsel, gap;

        wsel = int'(a[5:2]);
        s    = a[12:6];
        line = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = fixed ? (32'h100 + i) : $urandom;
            line[i*32 +: 32] = w[i];
        end
        for (int j = 0; j < 8; j++) begin
            cd[j*32 +: 32] = fixed ? 32'hABAB_ABAB : $urandom;
        end
        md = fixed ? 8'h12 : 8'($urandom);
        bs = fixed ? 32'h0000_0004 : $urandom;

        chk("accept_ready", ifc.miss_ready, 1);
        ifc.miss_valid = 1'b1;
        ifc.miss_addr  = a;
        tick;
        ifc.miss_valid = 1'b0;
        ifc.miss_addr  = $urandom;
        cyc = 1;
        stalls = 0;
        chk("mreq_valid", ifc.mem_req_valid, 1);
        chk("mreq_addr", ifc.mem_req_addr, {a[31:6], 6'd0});
        chk("mreq_busy", ifc.miss_ready, 0);
        repeat (ms) begin
            tick;
            cyc++;
            stalls++;
            chk("mreq_hold_valid", ifc.mem_req_valid, 1);
            chk("mreq_hold_addr", ifc.mem_req_addr, {a[31:6], 6'd0});
        end
        ifc.mem_req_ready = 1'b1;
        tick;
        cyc++;
        ifc.mem_req_ready = 1'b0;
        chk("mreq_drop", ifc.mem_req_valid, 0);

        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                tick;
                cyc++;
                stalls++;
            end
            ifc.mem_rsp_valid = 1'b1;
            ifc.mem_rsp_data  = w[i];
            tick;
            cyc++;
            ifc.mem_rsp_valid = 1'b0;
            ifc.mem_rsp_data  = $urandom;
            pulses += int'(ifc.fill_word_valid);
            if (i == wsel) begin
                chk("fill_word_valid", ifc.fill_word_valid, 1);
                chk("fill_word_data", ifc.fill_word_data, w[i]);
            end
            if (i == abort_at) return;
        end
        chk("fill_word_pulses", pulses, 1);

        chk("creq_valid", ifc.cmp_req_valid, 1);
        chk("creq_data", ifc.cmp_req_data, line);
        repeat (cs) begin
            tick;
            cyc++;
            stalls++;
            chk("creq_hold_valid", ifc.cmp_req_valid, 1);
            chk("creq_hold_data", ifc.cmp_req_data, line);
        end
        ifc.cmp_req_ready = 1'b1;
        tick;
        cyc++;
        ifc.cmp_req_ready = 1'b0;
        chk("creq_drop", ifc.cmp_req_valid, 0);

        ifc.cmp_rsp_valid = 1'b1;
        ifc.cmp_rsp_fit   = fit;
        ifc.cmp_rsp_data  = cd;
        ifc.cmp_rsp_mode  = md;
        ifc.cmp_rsp_base  = bs;
        tick;
        cyc++;
        ifc.cmp_rsp_valid = 1'b0;
        ifc.cmp_rsp_mode  = 8'($urandom);
        ifc.cmp_rsp_base  = $urandom;

        exp_idx  = {rr_m[s][2:0], s};
        rr_m[s]  = (rr_m[s] + 1) % WAYS;
        exp_dat  = fit ? {2'b11, a[31:13], cd} : {2'b01, a[31:13], line[255:0]};
        chk("wr_strobe", ifc.cache_write_on_demand, 1);
        chk("fill_done", ifc.fill_done, 1);
        chk("wr_index", ifc.cache_write_index, exp_idx);
        chk("wr_data", ifc.cache_write_data, exp_dat);
        chk("meta_mode", ifc.meta_write_mode, fit ? md : 8'h00);
        chk("meta_base", ifc.meta_write_base, fit ? bs : 32'h0);
        chk("latency", cyc, 20 + stalls);
        chk("write_not_ready", ifc.miss_ready, 0);
        last_idx = ifc.cache_write_index;

        tick;
        chk("wr_strobe_drop", ifc.cache_write_on_demand, 0);
        chk("fill_done_drop", ifc.fill_done, 0);
        chk("post_ready", ifc.miss_ready, 1);
        chk("wr_data_hold", ifc.cache_write_data, exp_dat);
        chk("wr_index_hold", ifc.cache_write_index, exp_idx);
    endtask

    initial begin
        logic [31:0] a;

        for (int s = 0; s < SETS; s++) rr_m[s] = 0;
        idle_inputs();

        #12;
        chk_quiet("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick;
        chk_quiet("after_reset");

        // Basic fill, then the same miss without a fit.
        do_miss(32'h0000_2048, 1'b1, 0, 0, 0, -1, 1'b1);
        chk("basic_index", last_idx, 10'h001);
        do_miss(32'h0000_2048, 1'b0, 0, 0, 0, -1, 1'b1);
        chk("nofit_index", last_idx, 10'h081);

        // Nine misses to set 5 with one set-6 miss interleaved.
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                a = $urandom;
                a[12:6] = 7'd6;
                do_miss(a, 1'($urandom_range(1, 0)), 0, 0, 0, -1, 1'b0);
                chk("rr_set6_index", last_idx, 10'h006);
            end
            a = $urandom;
            a[12:6] = 7'd5;
            do_miss(a, 1'($urandom_range(1, 0)), 0, 0, 0, -1, 1'b0);
        end
        chk("rr_wrap_index", last_idx, 10'h005);

        // Backpressure on every channel.
        do_miss($urandom, 1'($urandom_range(1, 0)), 5, 2, 3, -1, 1'b0);

        // Stray response word while idle.
        chk("proto_clear", ifc.proto_err, 0);
        ifc.mem_rsp_valid = 1'b1;
        ifc.mem_rsp_data  = $urandom;
        tick;
        ifc.mem_rsp_valid = 1'b0;
        chk("proto_set", ifc.proto_err, 1);
        chk("proto_no_write", ifc.cache_write_on_demand, 0);
        repeat (3) tick;
        chk("proto_sticky", ifc.proto_err, 1);
        chk("proto_no_done", ifc.fill_done, 0);
        do_miss($urandom, 1'b1, 0, 0, 0, -1, 1'b0);
        chk("proto_sticky_after", ifc.proto_err, 1);

        // Reset in the middle of the burst, after word 7.
        a = 32'h0000_2048;
        do_miss(a, 1'b1, 0, 0, 0, 7, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("mid_reset");
        for (int s = 0; s < SETS; s++) rr_m[s] = 0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        chk("reset_release_ready", ifc.miss_ready, 1);
        do_miss(a, 1'b1, 0, 0, 0, -1, 1'b0);
        chk("reset_way0", last_idx, 10'h001);

        repeat (6) begin
            do_miss($urandom, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
